// File: rtl/collision_detector.sv
// collision_detector: per-frame pacman vs ghost bounding-box overlap scanner
// Ports: clk_i/reset_n clock and async active-low reset; frame_tick_i starts a check
//   when game_state is PLAYING; pacman_*_i, ghost_*_i, ghost_active_i are the sprite
//   positions and enables; collision/ghost_hit_o hold the last completed result;
//   check_done_o pulses when results update; overrun_o is a sticky missed-tick flag.
module collision_detector #(
  parameter int NUM_GHOSTS  = 4,
  parameter int COORD_W     = 10,
  parameter int SPRITE_SIZE = 16
) (
  input  logic                          clk_i,
  input  logic                          reset_n,
  input  logic                          frame_tick_i,
  input  logic [1:0]                    game_state,
  input  logic [COORD_W-1:0]            pacman_x_i,
  input  logic [COORD_W-1:0]            pacman_y_i,
  input  logic [NUM_GHOSTS*COORD_W-1:0] ghost_x_i,
  input  logic [NUM_GHOSTS*COORD_W-1:0] ghost_y_i,
  input  logic [NUM_GHOSTS-1:0]         ghost_active_i,
  output logic                          collision,
  output logic [NUM_GHOSTS-1:0]         ghost_hit_o,
  output logic                          check_done_o,
  output logic                          overrun_o
);
  localparam int IW = NUM_GHOSTS > 1 ? $clog2(NUM_GHOSTS) : 1;
  localparam logic [1:0] PLAYING = 2'b10;
  localparam logic [COORD_W:0] SPRITE = (COORD_W+1)'(SPRITE_SIZE);
  localparam logic [IW-1:0] LAST = IW'(NUM_GHOSTS-1);
  typedef enum logic [1:0] {IDLE, LATCH, SCAN, UPDATE} state_t;
  state_t state_q, state_d;
  logic [COORD_W-1:0] px_q, px_d, py_q, py_d, gx_k, gy_k;
  logic [NUM_GHOSTS*COORD_W-1:0] gx_q, gx_d, gy_q, gy_d;
  logic [NUM_GHOSTS-1:0] act_q, act_d, acc_q, acc_d, hit_q, hit_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [COORD_W:0] dx, dy;
  logic coll_q, coll_d, done_q, done_d, ovr_q, ovr_d, hit_k;
  // Only the snapshot feeds the comparator, so inputs may move freely mid-scan.
  always_comb begin
    gx_k  = gx_q[int'(idx_q)*COORD_W +: COORD_W];
    gy_k  = gy_q[int'(idx_q)*COORD_W +: COORD_W];
    dx    = px_q >= gx_k ? {1'b0, px_q} - {1'b0, gx_k} : {1'b0, gx_k} - {1'b0, px_q};
    dy    = py_q >= gy_k ? {1'b0, py_q} - {1'b0, gy_k} : {1'b0, gy_k} - {1'b0, py_q};
    hit_k = act_q[idx_q] && dx < SPRITE && dy < SPRITE;
  end
  always_comb begin
    state_d = state_q;
    px_d    = px_q;
    py_d    = py_q;
    gx_d    = gx_q;
    gy_d    = gy_q;
    act_d   = act_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    hit_d   = hit_q;
    coll_d  = coll_q;
    done_d  = 1'b0;
    ovr_d   = ovr_q | (frame_tick_i && state_q != IDLE);
    // Leaving PLAYING aborts from any state and blanks the results.
    if (game_state != PLAYING) begin
      state_d = IDLE;
      acc_d   = '0;
      hit_d   = '0;
      coll_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE:    state_d = frame_tick_i ? LATCH : IDLE;
        LATCH: begin
          px_d    = pacman_x_i;
          py_d    = pacman_y_i;
          gx_d    = ghost_x_i;
          gy_d    = ghost_y_i;
          act_d   = ghost_active_i;
          acc_d   = '0;
          idx_d   = '0;
          state_d = SCAN;
        end
        SCAN: begin
          acc_d[idx_q] = hit_k;
          idx_d        = idx_q + 1'b1;
          state_d      = idx_q == LAST ? UPDATE : SCAN;
        end
        UPDATE: begin
          hit_d   = acc_q;
          coll_d  = |acc_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      endcase
    end
  end
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      px_q    <= '0;
      py_q    <= '0;
      gx_q    <= '0;
      gy_q    <= '0;
      act_q   <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      hit_q   <= '0;
      coll_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      px_q    <= px_d;
      py_q    <= py_d;
      gx_q    <= gx_d;
      gy_q    <= gy_d;
      act_q   <= act_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      hit_q   <= hit_d;
      coll_q  <= coll_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end
  assign collision    = coll_q;
  assign ghost_hit_o  = hit_q;
  assign check_done_o = done_q;
  assign overrun_o    = ovr_q;
endmodule

// File: tb/tb_collision_detector.sv
// tb_collision_detector: randomized self-checking bench with a distance-rule model
module tb_collision_detector;
  logic clk_i = 1'b0, reset_n = 1'b0, frame_tick_i = 1'b0;
  logic [1:0] game_state = 2'b00;
  logic [9:0] pac_x = '0, pac_y = '0;
  logic [9:0] gxa[4], gya[4];
  logic [3:0] act = '0;
  logic [39:0] ghost_x_i, ghost_y_i;
  logic collision, check_done_o, overrun_o;
  logic [3:0] ghost_hit_o;
  int errors = 0, checks = 0;
  assign ghost_x_i = {gxa[3], gxa[2], gxa[1], gxa[0]};
  assign ghost_y_i = {gya[3], gya[2], gya[1], gya[0]};
  collision_detector dut (
    .clk_i(clk_i), .reset_n(reset_n), .frame_tick_i(frame_tick_i),
    .game_state(game_state), .pacman_x_i(pac_x), .pacman_y_i(pac_y),
    .ghost_x_i(ghost_x_i), .ghost_y_i(ghost_y_i), .ghost_active_i(act),
    .collision(collision), .ghost_hit_o(ghost_hit_o),
    .check_done_o(check_done_o), .overrun_o(overrun_o)
  );
  always #5 clk_i = ~clk_i;
  function automatic logic [3:0] model_hits();
    logic [3:0] h = '0;
    for (int k = 0; k < 4; k++) begin
      int ddx, ddy;
      ddx = int'(pac_x) - int'(gxa[k]);
      ddy = int'(pac_y) - int'(gya[k]);
      if (ddx < 0) ddx = -ddx;
      if (ddy < 0) ddy = -ddy;
      h[k] = act[k] && ddx < 16 && ddy < 16;
    end
    return h;
  endfunction
  task automatic far_ghosts();
    for (int k = 0; k < 4; k++) begin
      gxa[k] = 10'd600;
      gya[k] = 10'd600;
    end
  endtask
  task automatic do_frame(output int lat, output int pulses);
    lat = -1;
    pulses = 0;
    @(negedge clk_i) frame_tick_i = 1'b1;
    @(negedge clk_i) frame_tick_i = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk_i);
      if (check_done_o) begin
        pulses++;
        if (lat < 0) lat = c;
      end
    end
  endtask
  task automatic test_reset();
    #1;
    checks++; if (collision !== 1'b0) begin errors++; $display("FAIL reset_collision got=%b exp=0", collision); end
    checks++; if (ghost_hit_o !== 4'b0) begin errors++; $display("FAIL reset_hit got=%b exp=0000", ghost_hit_o); end
    checks++; if (check_done_o !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", check_done_o); end
    checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", overrun_o); end
    repeat (2) @(negedge clk_i);
    reset_n = 1'b1;
    game_state = 2'b10;
  endtask
  task automatic test_basic();
    int lat, pulses;
    far_ghosts();
    pac_x = 10'd100; pac_y = 10'd100;
    gxa[0] = 10'd110; gya[0] = 10'd105;
    act = 4'b1111;
    do_frame(lat, pulses);
    checks++; if (lat !== 6) begin errors++; $display("FAIL basic_latency got=%0d exp=6", lat); end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL basic_pulses got=%0d exp=1", pulses); end
    checks++; if (collision !== 1'b1) begin errors++; $display("FAIL basic_collision got=%b exp=1", collision); end
    checks++; if (ghost_hit_o !== 4'b0001) begin errors++; $display("FAIL basic_hit got=%b exp=0001", ghost_hit_o); end
  endtask
  task automatic test_boundary();
    int lat, pulses;
    far_ghosts();
    pac_x = 10'd100; pac_y = 10'd100;
    gxa[2] = 10'd116; gya[2] = 10'd100;
    do_frame(lat, pulses);
    checks++; if (ghost_hit_o !== 4'b0000 || collision !== 1'b0) begin errors++; $display("FAIL boundary_16 got=%b/%b exp=0000/0", ghost_hit_o, collision); end
    gxa[2] = 10'd115;
    do_frame(lat, pulses);
    checks++; if (ghost_hit_o !== 4'b0100 || collision !== 1'b1) begin errors++; $display("FAIL boundary_15 got=%b/%b exp=0100/1", ghost_hit_o, collision); end
    gxa[2] = 10'd100; gya[2] = 10'd84;
    do_frame(lat, pulses);
    checks++; if (ghost_hit_o !== 4'b0000 || collision !== 1'b0) begin errors++; $display("FAIL boundary_y16 got=%b/%b exp=0000/0", ghost_hit_o, collision); end
  endtask
  task automatic test_wrap_inactive();
    int lat, pulses;
    far_ghosts();
    pac_x = 10'd0; pac_y = 10'd0;
    gxa[1] = 10'd1020; gya[1] = 10'd0;
    do_frame(lat, pulses);
    checks++; if (ghost_hit_o !== 4'b0000 || collision !== 1'b0) begin errors++; $display("FAIL wrap got=%b/%b exp=0000/0", ghost_hit_o, collision); end
    gxa[1] = 10'd5; gya[1] = 10'd5;
    act = 4'b1101;
    do_frame(lat, pulses);
    checks++; if (ghost_hit_o !== 4'b0000 || collision !== 1'b0) begin errors++; $display("FAIL inactive got=%b/%b exp=0000/0", ghost_hit_o, collision); end
    act = 4'b1111;
  endtask
  task automatic test_random();
    int lat, pulses;
    logic [3:0] exp_h;
    for (int n = 0; n < 24; n++) begin
      pac_x = 10'($urandom_range(0, 1023));
      pac_y = 10'($urandom_range(0, 1023));
      for (int k = 0; k < 4; k++) begin
        gxa[k] = 10'(int'(pac_x) + int'($urandom_range(0, 40)) - 20);
        gya[k] = 10'(int'(pac_y) + int'($urandom_range(0, 40)) - 20);
      end
      act = 4'($urandom_range(0, 15));
      exp_h = model_hits();
      do_frame(lat, pulses);
      checks++; if (ghost_hit_o !== exp_h || collision !== |exp_h || lat !== 6 || pulses !== 1) begin
        errors++; $display("FAIL random_%0d got=%b/%b lat=%0d n=%0d exp=%b/%b lat=6 n=1", n, ghost_hit_o, collision, lat, pulses, exp_h, |exp_h);
      end
    end
  endtask
  task automatic test_input_change();
    logic [3:0] exp_h;
    far_ghosts();
    pac_x = 10'd200; pac_y = 10'd200;
    act = 4'b1111;
    exp_h = model_hits();
    @(negedge clk_i) frame_tick_i = 1'b1;
    @(negedge clk_i) frame_tick_i = 1'b0;
    repeat (2) @(negedge clk_i);
    gxa[3] = 10'd201; gya[3] = 10'd199;
    repeat (10) @(negedge clk_i);
    checks++; if (ghost_hit_o !== exp_h || collision !== |exp_h) begin errors++; $display("FAIL input_change got=%b/%b exp=%b/%b", ghost_hit_o, collision, exp_h, |exp_h); end
  endtask
  task automatic test_overrun();
    int lat, pulses;
    far_ghosts();
    checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL overrun_pre got=%b exp=0", overrun_o); end
    pulses = 0;
    @(negedge clk_i) frame_tick_i = 1'b1;
    @(negedge clk_i) frame_tick_i = 1'b0;
    @(negedge clk_i) frame_tick_i = 1'b1;
    @(negedge clk_i) frame_tick_i = 1'b0;
    if (check_done_o) pulses++;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_i);
      if (check_done_o) pulses++;
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL overrun_pulses got=%0d exp=1", pulses); end
    checks++; if (overrun_o !== 1'b1) begin errors++; $display("FAIL overrun_set got=%b exp=1", overrun_o); end
    do_frame(lat, pulses);
    checks++; if (overrun_o !== 1'b1 || pulses !== 1) begin errors++; $display("FAIL overrun_sticky got=%b n=%0d exp=1 n=1", overrun_o, pulses); end
  endtask
  task automatic test_abort();
    int lat, pulses;
    far_ghosts();
    pac_x = 10'd300; pac_y = 10'd300;
    gxa[1] = 10'd305; gya[1] = 10'd310;
    do_frame(lat, pulses);
    checks++; if (collision !== 1'b1) begin errors++; $display("FAIL abort_setup got=%b exp=1", collision); end
    pulses = 0;
    @(negedge clk_i) frame_tick_i = 1'b1;
    @(negedge clk_i) frame_tick_i = 1'b0;
    repeat (3) @(negedge clk_i);
    game_state = 2'b11;
    @(negedge clk_i);
    checks++; if (collision !== 1'b0 || ghost_hit_o !== 4'b0) begin errors++; $display("FAIL abort_clear got=%b/%b exp=0/0000", collision, ghost_hit_o); end
    @(negedge clk_i) frame_tick_i = 1'b1;
    @(negedge clk_i) frame_tick_i = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_i);
      if (check_done_o || collision) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_quiet got=%0d exp=0", pulses); end
    game_state = 2'b10;
  endtask
  task automatic test_reset_midscan();
    int lat, pulses;
    do_frame(lat, pulses);
    checks++; if (collision !== 1'b1) begin errors++; $display("FAIL rst_setup got=%b exp=1", collision); end
    @(negedge clk_i) frame_tick_i = 1'b1;
    @(negedge clk_i) frame_tick_i = 1'b0;
    repeat (3) @(negedge clk_i);
    reset_n = 1'b0;
    #1;
    checks++; if (collision !== 1'b0 || ghost_hit_o !== 4'b0 || check_done_o !== 1'b0 || overrun_o !== 1'b0) begin
      errors++; $display("FAIL rst_async got=%b/%b/%b/%b exp=0/0000/0/0", collision, ghost_hit_o, check_done_o, overrun_o);
    end
    @(negedge clk_i);
    @(negedge clk_i) reset_n = 1'b1;
    repeat (8) @(negedge clk_i);
    checks++; if (check_done_o !== 1'b0 || collision !== 1'b0) begin errors++; $display("FAIL rst_no_resume got=%b/%b exp=0/0", check_done_o, collision); end
    far_ghosts();
    do_frame(lat, pulses);
    checks++; if (lat !== 6 || pulses !== 1 || collision !== 1'b0 || ghost_hit_o !== 4'b0) begin
      errors++; $display("FAIL rst_after got=lat%0d n%0d %b/%b exp=lat6 n1 0/0000", lat, pulses, collision, ghost_hit_o);
    end
  endtask
  initial begin
    far_ghosts();
    test_reset();
    test_basic();
    test_boundary();
    test_wrap_inactive();
    test_random();
    test_input_change();
    test_overrun();
    test_abort();
    test_reset_midscan();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/collision_detector.md
COLLISION_DETECTOR -- requirements
Module: collision_detector

Interface
REQ-001 SHALL have parameter NUM_GHOSTS, default 4, number of ghost slots scanned per frame.
REQ-002 SHALL have parameter COORD_W, default 10, coordinate width in pixels.
REQ-003 SHALL have parameter SPRITE_SIZE, default 16, sprite bounding-box edge in pixels.
REQ-004 SHALL have port clk_i  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port frame_tick_i  input  1  one-cycle pulse at start of vertical blank.
REQ-007 SHALL have port game_state  input  2  state from game_state_controller (00 TITLE, 10 PLAYING, 11 GAME_OVER).
REQ-008 SHALL have port pacman_x_i / pacman_y_i  input  COORD_W each  pacman top-left corner.
REQ-009 SHALL have port ghost_x_i / ghost_y_i  input  NUM_GHOSTS*COORD_W each  packed ghost corners; ghost k at bits [k*COORD_W +: COORD_W].
REQ-010 SHALL have port ghost_active_i  input  NUM_GHOSTS  per-ghost enable.
REQ-011 SHALL have port collision  output  1  level; high while the last completed check found any hit.
REQ-012 SHALL have port ghost_hit_o  output  NUM_GHOSTS  per-ghost hit vector from the last completed check.
REQ-013 SHALL have port check_done_o  output  1  one-cycle pulse when results update.
REQ-014 SHALL have port overrun_o  output  1  sticky; a frame tick arrived while a check was in progress.

Function
REQ-015 SHALL implement FSM states IDLE, LATCH, SCAN, UPDATE.
REQ-016 IDLE -> LATCH SHALL occur when frame_tick_i=1 and game_state=PLAYING; otherwise stay in IDLE.
REQ-017 LATCH SHALL snapshot every coordinate input and ghost_active_i into internal registers, clear the scan index and hit accumulator, then go to SCAN.
REQ-018 SCAN SHALL evaluate exactly one ghost per cycle, index 0 upward, from snapshot values only; after index NUM_GHOSTS-1 it goes to UPDATE.
REQ-019 Ghost k SHALL hit iff active and |px-gx| < SPRITE_SIZE and |py-gy| < SPRITE_SIZE; differences computed COORD_W+1 bits wide, no wrap; equality to SPRITE_SIZE is a miss.
REQ-020 UPDATE SHALL load ghost_hit_o with the accumulator, set collision = OR of the accumulator, pulse check_done_o for exactly one cycle, and return to IDLE.
REQ-021 Latency SHALL be fixed: with tick sampled at edge E0, outputs change and check_done_o rises at edge E(NUM_GHOSTS+2), i.e. E6 for the default.
REQ-022 collision and ghost_hit_o SHALL hold between updates so a persistent overlap gives a continuous level to the consumer.
REQ-023 frame_tick_i while not in IDLE SHALL be ignored and SHALL set overrun_o; overrun_o clears only on reset.
REQ-024 game_state leaving PLAYING in any state SHALL abort to IDLE on the next edge, clearing collision, ghost_hit_o and the accumulator with no check_done_o pulse.
REQ-025 While game_state is not PLAYING, collision and ghost_hit_o SHALL remain 0.
REQ-026 Input changes after LATCH SHALL not affect the check in progress.

Reset
REQ-027 reset_n=0 SHALL force state IDLE and collision=0, ghost_hit_o=0, check_done_o=0, overrun_o=0 immediately, regardless of the clock.
REQ-028 Reset asserted mid-SCAN SHALL discard the partial result; the first check after release starts on the next qualifying tick.

Verification
REQ-029 PLAYING, pacman (100,100), ghost0 (110,105) active, others far; tick -> E6: collision=1, ghost_hit_o=0001, one-cycle check_done_o.
REQ-030 Boundary: pacman (100,100), ghost2 (116,100) -> miss; ghost2 (115,100) -> ghost_hit_o=0100, collision=1.
REQ-031 Wrap: pacman (0,0), ghost1 (1020,0) -> no hit; ghost overlapping but ghost_active_i=0 -> no hit.
REQ-032 Second tick two cycles after the first -> overrun_o=1 and stays 1; exactly one check_done_o pulse.
REQ-033 game_state changed to GAME_OVER during SCAN -> next edge: collision=0, ghost_hit_o=0, no check_done_o; ticks then ignored.
REQ-034 reset_n pulsed low mid-SCAN with collision=1 held -> all outputs 0 asynchronously; a later tick with no overlap completes normally with collision=0.
